// File: rtl/uart_dbg_master.sv
// UART byte-stream debug bus master; optional inter-byte frame timeout under UART_DBG_TIMEOUT_EN.
// Latency: bus strobe 1 cycle after last frame byte, first response byte 1 cycle after strobe.
// Backpressure: rx stalled outside IDLE/ADDR/WDATA; tx byte held stable until tx_byte_ready_i.
module uart_dbg_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [7:0]            rx_byte_i,
  input  logic                  rx_byte_valid_i,
  output logic                  rx_byte_ready_o,
  output logic [7:0]            tx_byte_o,
  output logic                  tx_byte_valid_o,
  input  logic                  tx_byte_ready_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_wstrb_o,
  input  logic [1:0]            mem_wresp_i,
  output logic                  mem_re_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic [1:0]            mem_rresp_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_READ, S_RESP
  } state_e;

  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_READ  = 8'h5A;

  state_e                state_q, state_d;
  logic                  op_wr_q, op_wr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            len_q, len_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  rx_rdy_q, rx_rdy_d;
  logic                  busy_q, busy_d;
  logic                  rx_fire, tx_fire;
  logic [31:0]           addr_shift, data_shift;
`ifdef UART_DBG_TIMEOUT_EN
  logic [31:0]           to_cnt_q, to_cnt_d;
`endif

  assign rx_fire    = rx_byte_valid_i && rx_rdy_q;
  assign tx_fire    = tx_vld_q && tx_byte_ready_i;
  // Little-endian assembly: each new byte enters at the top and slides down.
  assign addr_shift = {rx_byte_i, addr_q[31:8]};
  assign data_shift = {rx_byte_i, data_q[31:8]};

  always_comb begin
    state_d   = state_q;
    op_wr_d   = op_wr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    data_d    = data_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    tx_byte_d = tx_byte_q;
    tx_vld_d  = tx_vld_q;
    rx_rdy_d  = 1'b0;
    busy_d    = 1'b0;
`ifdef UART_DBG_TIMEOUT_EN
    to_cnt_d  = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          cnt_d = 3'd0;
          if (rx_byte_i == CMD_WRITE) begin
            state_d = S_ADDR;
            op_wr_d = 1'b1;
          end else if (rx_byte_i == CMD_READ) begin
            state_d = S_ADDR;
            op_wr_d = 1'b0;
          end
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          addr_d = addr_shift;
          if (cnt_q == 3'd3) begin
            cnt_d = 3'd0;
            if (op_wr_q) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_READ;
              re_d    = 1'b1;
              raddr_d = addr_shift[ADDR_WIDTH-1:0];
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          data_d = data_shift;
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            state_d = S_WRITE;
            we_d    = 1'b1;
            waddr_d = addr_q[ADDR_WIDTH-1:0];
            wdata_d = data_shift;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_WRITE: begin
        state_d   = S_RESP;
        tx_byte_d = {6'b0, mem_wresp_i};
        tx_vld_d  = 1'b1;
        len_d     = 3'd1;
        cnt_d     = 3'd0;
      end
      S_READ: begin
        state_d   = S_RESP;
        data_d    = mem_rdata_i;
        tx_byte_d = {6'b0, mem_rresp_i};
        tx_vld_d  = 1'b1;
        len_d     = 3'd5;
        cnt_d     = 3'd0;
      end
      S_RESP: begin
        if (tx_fire) begin
          if (cnt_q == len_q - 3'd1) begin
            state_d  = S_IDLE;
            tx_vld_d = 1'b0;
            cnt_d    = 3'd0;
          end else begin
            // Read data leaves D0 first; drain the latched word from the bottom.
            cnt_d     = cnt_q + 3'd1;
            tx_byte_d = data_q[7:0];
            data_d    = {8'h00, data_q[31:8]};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_DBG_TIMEOUT_EN
    if ((state_q == S_ADDR || state_q == S_WDATA) && !rx_fire) begin
      if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
        state_d   = S_RESP;
        tx_byte_d = 8'hEE;
        tx_vld_d  = 1'b1;
        len_d     = 3'd1;
        cnt_d     = 3'd0;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
`endif

    rx_rdy_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= S_IDLE;
      op_wr_q   <= 1'b0;
      cnt_q     <= 3'd0;
      len_q     <= 3'd0;
      addr_q    <= '0;
      data_q    <= '0;
      waddr_q   <= '0;
      raddr_q   <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      tx_byte_q <= 8'h00;
      tx_vld_q  <= 1'b0;
      rx_rdy_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_DBG_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_wr_q   <= op_wr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      tx_byte_q <= tx_byte_d;
      tx_vld_q  <= tx_vld_d;
      rx_rdy_q  <= rx_rdy_d;
      busy_q    <= busy_d;
`ifdef UART_DBG_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign rx_byte_ready_o = rx_rdy_q;
  assign tx_byte_o       = tx_byte_q;
  assign tx_byte_valid_o = tx_vld_q;
  assign mem_we_o        = we_q;
  assign mem_waddr_o     = waddr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wstrb_o     = 4'hF;
  assign mem_re_o        = re_q;
  assign mem_raddr_o     = raddr_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_uart_dbg_master.sv
// Scoreboard bench for uart_dbg_master: expected bus ops and tx bytes queued at stimulus time.
module tb_uart_dbg_master;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic [7:0]  rx_byte_i = 8'h00;
  logic        rx_byte_valid_i = 1'b0;
  logic        rx_byte_ready_o;
  logic [7:0]  tx_byte_o;
  logic        tx_byte_valid_o;
  logic        tx_byte_ready_i = 1'b1;
  logic        mem_we_o;
  logic [31:0] mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [1:0]  mem_wresp_i = 2'd0;
  logic        mem_re_o;
  logic [31:0] mem_raddr_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic [1:0]  mem_rresp_i = 2'd0;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  logic       prev_strobe = 1'b0;

  always #5 clk_i = ~clk_i;

  uart_dbg_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .rx_byte_i(rx_byte_i), .rx_byte_valid_i(rx_byte_valid_i), .rx_byte_ready_o(rx_byte_ready_o),
    .tx_byte_o(tx_byte_o), .tx_byte_valid_o(tx_byte_valid_o), .tx_byte_ready_i(tx_byte_ready_i),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_wresp_i(mem_wresp_i),
    .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
    .mem_rresp_i(mem_rresp_i), .busy_o(busy_o)
  );

  // Output monitor: bus strobes and tx handshakes are popped against the scoreboard.
  always @(negedge clk_i) begin
    if (arst_ni) begin
      if (mem_we_o || mem_re_o) begin
        checks++;
        if (mem_we_o && mem_re_o) begin
          errors++; $display("FAIL strobe_both: we=%0b re=%0b required exclusive", mem_we_o, mem_re_o);
        end else if (prev_strobe) begin
          errors++; $display("FAIL strobe_width: strobe high two cycles, required one");
        end else if (exp_bus.size() == 0) begin
          errors++; $display("FAIL strobe_unexpected: we=%0b re=%0b waddr=%h raddr=%h", mem_we_o, mem_re_o, mem_waddr_o, mem_raddr_o);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          if (mem_we_o !== e.wr)
            begin errors++; $display("FAIL bus_kind: we=%0b required %0b", mem_we_o, e.wr); end
          else if (e.wr && (mem_waddr_o !== e.addr || mem_wdata_o !== e.data || mem_wstrb_o !== 4'hF))
            begin errors++; $display("FAIL bus_write: addr=%h data=%h strb=%h required %h %h F", mem_waddr_o, mem_wdata_o, mem_wstrb_o, e.addr, e.data); end
          else if (!e.wr && mem_raddr_o !== e.addr)
            begin errors++; $display("FAIL bus_read: addr=%h required %h", mem_raddr_o, e.addr); end
        end
      end
      prev_strobe = mem_we_o || mem_re_o;
      if (tx_byte_valid_o && tx_byte_ready_i) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++; $display("FAIL tx_unexpected: byte=%h", tx_byte_o);
        end else begin
          logic [7:0] eb;
          eb = exp_tx.pop_front();
          if (tx_byte_o !== eb) begin
            errors++; $display("FAIL tx_byte: got %h required %h", tx_byte_o, eb);
          end
        end
      end
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int  n;
    logic done;
    n = 0; done = 1'b0;
    rx_byte_i = b; rx_byte_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk_i);
      if (rx_byte_ready_o) done = 1'b1;
      else if (++n > 500) begin
        checks++; errors++; done = 1'b1;
        $display("FAIL rx_accept_timeout: byte %h not accepted", b);
      end
    end
    @(posedge clk_i); #1;
    rx_byte_valid_i = 1'b0;
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic push_read_resp(input logic [1:0] r, input logic [31:0] d);
    exp_tx.push_back({6'b0, r});
    for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    checks++;
    do begin
      @(negedge clk_i); n++;
    end while ((exp_tx.size() != 0 || exp_bus.size() != 0 || busy_o || tx_byte_valid_o) && n < 400);
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_drain: tx_left=%0d bus_left=%0d busy=%0b", name, exp_tx.size(), exp_bus.size(), busy_o);
      exp_tx.delete(); exp_bus.delete();
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({tx_byte_valid_o, tx_byte_o, mem_we_o, mem_re_o, busy_o, rx_byte_ready_o} !== 13'h0 ||
        mem_waddr_o !== 32'h0 || mem_raddr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_wstrb_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_values: txv=%0b tx=%h we=%0b re=%0b busy=%0b rdy=%0b wa=%h ra=%h wd=%h strb=%h required zeros and strb F",
               tx_byte_valid_o, tx_byte_o, mem_we_o, mem_re_o, busy_o, rx_byte_ready_o, mem_waddr_o, mem_raddr_o, mem_wdata_o, mem_wstrb_o);
    end
    repeat (2) @(posedge clk_i); #1;
    arst_ni = 1'b1;
    repeat (2) @(posedge clk_i); #1;
    checks++;
    if (rx_byte_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: rdy=%0b busy=%0b required 1 0", rx_byte_ready_o, busy_o);
    end
  endtask

  task automatic test_write();
    mem_wresp_i = 2'd0;
    exp_bus.push_back('{1'b1, 32'h10, 32'hDEADBEEF});
    exp_tx.push_back(8'h00);
    send_write(32'h10, 32'hDEADBEEF);
    @(negedge clk_i);
    checks++;
    if (mem_we_o !== 1'b1) begin
      errors++; $display("FAIL write_latency: we=%0b one cycle after last byte, required 1", mem_we_o);
    end
    @(negedge clk_i);
    checks++;
    if (tx_byte_valid_o !== 1'b1 || mem_we_o !== 1'b0) begin
      errors++; $display("FAIL write_resp_latency: txv=%0b we=%0b required 1 0", tx_byte_valid_o, mem_we_o);
    end
    wait_idle("write");
    checks++;
    if (mem_waddr_o !== 32'h10 || mem_wdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_hold: addr=%h data=%h required 00000010 deadbeef", mem_waddr_o, mem_wdata_o);
    end
  endtask

  task automatic test_read();
    mem_rdata_i = 32'h12345678; mem_rresp_i = 2'd2;
    exp_bus.push_back('{1'b0, 32'h04, 32'h0});
    push_read_resp(2'd2, 32'h12345678);
    send_read(32'h04);
    @(negedge clk_i);
    checks++;
    if (mem_re_o !== 1'b1) begin
      errors++; $display("FAIL read_latency: re=%0b required 1", mem_re_o);
    end
    wait_idle("read");
  endtask

  task automatic test_garbage();
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (3) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || tx_byte_valid_o !== 1'b0) begin
      errors++; $display("FAIL garbage_idle: busy=%0b txv=%0b required 0 0", busy_o, tx_byte_valid_o);
    end
    @(posedge clk_i); #1;
    mem_rdata_i = 32'hA1B2C3D4; mem_rresp_i = 2'd1;
    exp_bus.push_back('{1'b0, 32'h00000100, 32'h0});
    push_read_resp(2'd1, 32'hA1B2C3D4);
    send_read(32'h00000100);
    wait_idle("garbage_read");
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    tx_byte_ready_i = 1'b0;
    mem_rdata_i = 32'hCAFEF00D; mem_rresp_i = 2'd0;
    exp_bus.push_back('{1'b0, 32'h00000200, 32'h0});
    push_read_resp(2'd0, 32'hCAFEF00D);
    send_read(32'h00000200);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!tx_byte_valid_o && n < 20);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (tx_byte_valid_o !== 1'b1 || tx_byte_o !== 8'h00 || rx_byte_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++; bad++;
        if (bad < 3)
          $display("FAIL backpressure_hold: txv=%0b tx=%h rdy=%0b busy=%0b required 1 00 0 1",
                   tx_byte_valid_o, tx_byte_o, rx_byte_ready_o, busy_o);
      end
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;
    tx_byte_ready_i = 1'b1;
    wait_idle("backpressure");
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hA5);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    arst_ni = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || rx_byte_ready_o !== 1'b0 || mem_we_o !== 1'b0) begin
      errors++; $display("FAIL reset_midframe: busy=%0b rdy=%0b we=%0b required 0 0 0", busy_o, rx_byte_ready_o, mem_we_o);
    end
    @(posedge clk_i); #1;
    arst_ni = 1'b1;
    @(posedge clk_i); #1;
    mem_wresp_i = 2'd3;
    exp_bus.push_back('{1'b1, 32'h00000020, 32'h01020304});
    exp_tx.push_back(8'h03);
    send_write(32'h00000020, 32'h01020304);
    wait_idle("reset_midframe");
  endtask

  task automatic test_back_to_back();
    mem_wresp_i = 2'd1;
    mem_rdata_i = 32'h89ABCDEF; mem_rresp_i = 2'd0;
    exp_bus.push_back('{1'b1, 32'h80000004, 32'h55AA33CC});
    exp_tx.push_back(8'h01);
    exp_bus.push_back('{1'b0, 32'h80000008, 32'h0});
    push_read_resp(2'd0, 32'h89ABCDEF);
    send_write(32'h80000004, 32'h55AA33CC);
    send_read(32'h80000008);
    wait_idle("back_to_back");
  endtask

  task automatic test_stall();
    send_byte(8'hA5);
    send_byte(8'h01);
`ifdef UART_DBG_TIMEOUT_EN
    exp_tx.push_back(8'hEE);
    wait_idle("timeout");
    checks++;
    if (busy_o !== 1'b0 || rx_byte_ready_o !== 1'b1) begin
      errors++; $display("FAIL timeout_idle: busy=%0b rdy=%0b required 0 1", busy_o, rx_byte_ready_o);
    end
`else
    repeat (40) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1 || tx_byte_valid_o !== 1'b0 || rx_byte_ready_o !== 1'b1) begin
      errors++; $display("FAIL stall_wait: busy=%0b txv=%0b rdy=%0b required 1 0 1", busy_o, tx_byte_valid_o, rx_byte_ready_o);
    end
    @(posedge clk_i); #1;
    mem_wresp_i = 2'd0;
    exp_bus.push_back('{1'b1, 32'h04030201, 32'h0BADF00D});
    exp_tx.push_back(8'h00);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    for (int i = 0; i < 4; i++) send_byte(8'(32'h0BADF00D >> (8*i)));
    wait_idle("stall_complete");
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_garbage();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_stall();
    repeat (5) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
